reservation_station: RTL and testbench
======================================

Name: reservation_station

Overview:
- Sits directly downstream of instruction_queue and upstream of the ALU in the OOPs out-of-order core.
- Accepts instruction_element_t entries over a valid/ready handshake and holds up to DEPTH of them.
- Snoops the common data bus (CDB) to resolve operands that are waiting on ROB tags.
- Issues the oldest entry whose operands are both resolved to the functional unit.

Parameters:
- DEPTH, 4, number of entries (2..16).
- WIDTH, 32, operand data width.
- TAG_WIDTH, 4, ROB tag width; matches ROB_dest.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous squash of all entries.
- vld_i  in  1  upstream entry valid.
- rdy_i  out  1  station can accept an entry.
- instruction_i  in  instruction_element_t  incoming entry.
- cdb_vld_i  in  1  CDB broadcast valid.
- cdb_tag_i  in  TAG_WIDTH  ROB tag being broadcast.
- cdb_data_i  in  WIDTH  result value for cdb_tag_i.
- vld_o  out  1  instruction_o is issuable.
- rdy_o  in  1  functional unit accepts this cycle.
- instruction_o  out  instruction_element_t  issued entry, CB1=CB2=0.

Behaviour:
- Operand encoding:
  - CBx=1: valx[TAG_WIDTH-1:0] holds a pending ROB tag.
  - CBx=0: valx holds operand data.
- Storage is a collapsing queue. Index 0 is the oldest entry; valid entries are contiguous from index 0; count = number of valid entries.
- Reset (async):
  - All valid bits 0, count 0.
  - vld_o=0, rdy_i=0 while rst is high.
  - instruction_o = '0.
- rdy_i = !rst && (count < DEPTH). It depends only on registered state. When full, no allocation is possible even in a cycle where an issue also happens.
- Allocate:
  - Occurs when vld_i && rdy_i && !flush.
  - The entry is written at index count, or count-1 if an issue fires in the same cycle.
- Wakeup:
  - Every cycle cdb_vld_i is high, each valid entry with CBx=1 and tag==cdb_tag_i loads valx<=cdb_data_i and clears CBx.
  - Applies to both operands independently.
  - Also applies to the entry being allocated in that same cycle, which captures the data at write.
- Ready: an entry is ready when it is valid and CB1==0 and CB2==0, evaluated on registered state.
- Select: the lowest-index ready entry, driven combinationally onto instruction_o. vld_o = that entry exists && !flush.
- Issue:
  - Fires when vld_o && rdy_o. The selected entry is removed at the edge; all higher entries shift down one index, keeping age order.
  - Entries captured or woken this cycle are not issuable until the next cycle (1-cycle wakeup-to-issue minimum).
- Stall: while vld_o && !rdy_o, the selected entry may change if an older entry becomes ready. The consumer samples only on a fire.
- Flush:
  - Clears all valid bits at the edge; count becomes 0.
  - Has priority over allocate, issue, and wakeup in the same cycle.
  - vld_o is forced to 0 during the flush cycle.
- Reset mid-operation discards all entries immediately, with no partial shift.
- A CDB tag matching no entry has no effect. Duplicate tag matches across entries all wake.

Optional Feature:
- Macro: RS_CDB_BYPASS_EN.
- Defined:
  - An entry whose last pending operand matches the CDB this cycle counts as ready in the same cycle.
  - instruction_o carries cdb_data_i in place of the tag, with CB cleared.
  - Zero-cycle wakeup-to-issue; this also applies to the entry being allocated.
- Undefined: the 1-cycle minimum described above.

Decomposition:
- oops_structs gains:
  - cdb_t: vld, tag, data.
  - rs_entry_t: valid + instruction_element_t.
  - Constant RS_DEPTH_DEFAULT.
- Sub-module rs_operand_capture, instantiated 2 × DEPTH (plus 2 for the allocate path):
  - Inputs: CB, val, CDB.
  - Outputs: next CB and next val.
  - Compare-and-mux only.

Test Plan:
- Reset, then allocate imm_add with CB1=CB2=0, val1=2, val2=1, rdy_o=1 → vld_o=1 on the next cycle with val1=2, val2=1; after the fire, vld_o=0 and rdy_i=1.
- Allocate with CB1=1, val1=3, CB2=0; broadcast tag 3, data 32'hDEADBEEF two cycles later → vld_o rises 1 cycle after the broadcast with val1=32'hDEADBEEF, CB1=0.
- Allocate A (tag 5 pending) then B (ready), rdy_o=1 → B issues first. Broadcast tag 5 → A issues next cycle. Count returns to 0.
- Fill 4 entries with tag 7 pending → rdy_i=0, vld_i ignored. One broadcast of tag 7 wakes all 4 → they issue in order 0..3 over 4 cycles.
- 3 valid entries, assert flush together with vld_i and cdb_vld_i → next cycle count=0, vld_o=0, rdy_i=1, nothing issued.
- With RS_CDB_BYPASS_EN: allocate in the same cycle as a matching CDB broadcast of 32'h0000000E → vld_o=1 that cycle with val1=32'h0000000E.

Source files
------------

// File: rtl/reservation_station_pkg.sv
// Shared OOPs core types for the reservation station: instruction entry, CDB
// broadcast, and the stored entry wrapper with its valid bit.
package reservation_station_pkg;

  localparam int RS_WIDTH         = 32;
  localparam int RS_TAG_WIDTH     = 4;
  localparam int RS_DEPTH_DEFAULT = 4;

  typedef enum logic [3:0] {
    OP_ADD     = 4'd0,
    OP_SUB     = 4'd1,
    OP_IMM_ADD = 4'd2,
    OP_AND     = 4'd3,
    OP_OR      = 4'd4,
    OP_XOR     = 4'd5,
    OP_SLL     = 4'd6,
    OP_SRL     = 4'd7
  } opcode_t;

  // CBx=1 means valx[RS_TAG_WIDTH-1:0] is a pending ROB tag, else valx is data.
  typedef struct packed {
    opcode_t                 opcode;
    logic [RS_TAG_WIDTH-1:0] ROB_dest;
    logic                    CB1;
    logic [RS_WIDTH-1:0]     val1;
    logic                    CB2;
    logic [RS_WIDTH-1:0]     val2;
  } instruction_element_t;

  typedef struct packed {
    logic                    vld;
    logic [RS_TAG_WIDTH-1:0] tag;
    logic [RS_WIDTH-1:0]     data;
  } cdb_t;

  typedef struct packed {
    logic                 valid;
    instruction_element_t instr;
  } rs_entry_t;

  function automatic logic entry_ready(input rs_entry_t e);
    return e.valid && !e.instr.CB1 && !e.instr.CB2;
  endfunction

endpackage

// File: rtl/reservation_station_operand_capture.sv
// One operand's CDB snoop: when the operand waits on the broadcast tag, take
// the broadcast data and clear the pending flag.
module rs_operand_capture
  import reservation_station_pkg::*;
(
  input  logic                cb,
  input  logic [RS_WIDTH-1:0] val,
  input  cdb_t                cdb,
  output logic                cb_n,
  output logic [RS_WIDTH-1:0] val_n
);

  logic hit;

  assign hit   = cdb.vld && cb && (val[RS_TAG_WIDTH-1:0] == cdb.tag);
  assign cb_n  = cb && !hit;
  assign val_n = hit ? cdb.data : val;

endmodule

// File: rtl/reservation_station.sv
// Collapsing-queue reservation station: oldest-ready select, CDB wakeup, flush.
// Define RS_CDB_BYPASS_EN to let a CDB hit make an entry issuable in the same cycle.
module reservation_station
  import reservation_station_pkg::*;
#(
  parameter int DEPTH     = RS_DEPTH_DEFAULT,
  parameter int WIDTH     = RS_WIDTH,
  parameter int TAG_WIDTH = RS_TAG_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 vld_i,
  output logic                 rdy_i,
  input  instruction_element_t instruction_i,
  input  logic                 cdb_vld_i,
  input  logic [TAG_WIDTH-1:0] cdb_tag_i,
  input  logic [WIDTH-1:0]     cdb_data_i,
  output logic                 vld_o,
  input  logic                 rdy_o,
  output instruction_element_t instruction_o
);

  localparam int CW = $clog2(DEPTH + 1);
  typedef logic [CW-1:0] cnt_t;

  rs_entry_t [DEPTH-1:0]                ent_q, ent_n;
  rs_entry_t [DEPTH:0]                  woke;
  logic [DEPTH-1:0]                     cb1_w, cb2_w;
  logic [DEPTH-1:0][RS_WIDTH-1:0]       v1_w, v2_w;
  logic                                 a_cb1, a_cb2;
  logic [RS_WIDTH-1:0]                  a_v1, a_v2;
  instruction_element_t                 alloc_w;
  instruction_element_t [DEPTH:0]       cand;
  logic [DEPTH:0]                       rdy;
  cnt_t                                 count_q, count_n, sel_idx, wr_idx;
  logic                                 sel_found, alloc, fire, fire_in, shift, wr_en;
  cdb_t                                 cdb;

  assign cdb = '{vld: cdb_vld_i, tag: cdb_tag_i, data: cdb_data_i};

  for (genvar i = 0; i < DEPTH; i++) begin : g_lane
    rs_operand_capture u_op1 (
      .cb(ent_q[i].instr.CB1), .val(ent_q[i].instr.val1), .cdb(cdb),
      .cb_n(cb1_w[i]), .val_n(v1_w[i])
    );
    rs_operand_capture u_op2 (
      .cb(ent_q[i].instr.CB2), .val(ent_q[i].instr.val2), .cdb(cdb),
      .cb_n(cb2_w[i]), .val_n(v2_w[i])
    );
  end

  // The incoming entry snoops the same broadcast so it is never written stale.
  rs_operand_capture u_alloc_op1 (
    .cb(instruction_i.CB1), .val(instruction_i.val1), .cdb(cdb),
    .cb_n(a_cb1), .val_n(a_v1)
  );
  rs_operand_capture u_alloc_op2 (
    .cb(instruction_i.CB2), .val(instruction_i.val2), .cdb(cdb),
    .cb_n(a_cb2), .val_n(a_v2)
  );

  always_comb begin
    woke = '0;
    for (int i = 0; i < DEPTH; i++) begin
      woke[i]            = ent_q[i];
      woke[i].instr.CB1  = cb1_w[i];
      woke[i].instr.val1 = v1_w[i];
      woke[i].instr.CB2  = cb2_w[i];
      woke[i].instr.val2 = v2_w[i];
    end
    alloc_w      = instruction_i;
    alloc_w.CB1  = a_cb1;
    alloc_w.val1 = a_v1;
    alloc_w.CB2  = a_cb2;
    alloc_w.val2 = a_v2;
  end

  assign rdy_i = !rst && (count_q < cnt_t'(DEPTH));

  // Slot DEPTH stands for the entry being allocated; it is always the youngest.
  always_comb begin
    rdy  = '0;
    cand = '0;
    for (int i = 0; i < DEPTH; i++) begin
`ifdef RS_CDB_BYPASS_EN
      rdy[i]  = entry_ready(woke[i]);
      cand[i] = woke[i].instr;
`else
      rdy[i]  = entry_ready(ent_q[i]);
      cand[i] = ent_q[i].instr;
`endif
    end
`ifdef RS_CDB_BYPASS_EN
    rdy[DEPTH]  = vld_i && rdy_i && !a_cb1 && !a_cb2;
    cand[DEPTH] = alloc_w;
`else
    rdy[DEPTH]  = 1'b0;
    cand[DEPTH] = '0;
`endif
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i <= DEPTH; i++) begin
      if (rdy[i] && !sel_found) begin
        sel_found = 1'b1;
        sel_idx   = cnt_t'(i);
      end
    end
  end

  always_comb begin
    instruction_o = '0;
    if (sel_found) begin
      instruction_o     = cand[sel_idx];
      instruction_o.CB1 = 1'b0;
      instruction_o.CB2 = 1'b0;
    end
    vld_o = sel_found && !flush && !rst;
  end

  always_comb begin
    alloc   = vld_i && rdy_i && !flush;
    fire    = vld_o && rdy_o;
    fire_in = fire && (sel_idx == cnt_t'(DEPTH));
    shift   = fire && !fire_in;
    wr_en   = alloc && !fire_in;
    wr_idx  = count_q - cnt_t'(shift);
    ent_n   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (shift && (cnt_t'(i) >= sel_idx)) ent_n[i] = woke[i+1];
      else                                 ent_n[i] = woke[i];
      if (wr_en && (cnt_t'(i) == wr_idx))  ent_n[i] = '{valid: 1'b1, instr: alloc_w};
      if (flush)                           ent_n[i] = '0;
    end
    if (flush) count_n = '0;
    else       count_n = count_q + cnt_t'(wr_en) - cnt_t'(shift);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_q   <= '0;
      count_q <= '0;
    end else begin
      ent_q   <= ent_n;
      count_q <= count_n;
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// Directed + random bench for reservation_station against a queue-based age-ordered model.
module tb_reservation_station;
  import reservation_station_pkg::*;

  localparam int DEPTH = 4;

  logic                 clk = 1'b0;
  logic                 rst, flush, vld_i, rdy_i, cdb_vld_i, vld_o, rdy_o;
  logic [3:0]           cdb_tag_i;
  logic [31:0]          cdb_data_i;
  instruction_element_t instruction_i, instruction_o;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;
  instruction_element_t mq[$];

  reservation_station #(.DEPTH(DEPTH), .WIDTH(32), .TAG_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .vld_i(vld_i), .rdy_i(rdy_i),
    .instruction_i(instruction_i), .cdb_vld_i(cdb_vld_i), .cdb_tag_i(cdb_tag_i),
    .cdb_data_i(cdb_data_i), .vld_o(vld_o), .rdy_o(rdy_o), .instruction_o(instruction_o)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic instruction_element_t mk(input opcode_t op, input logic [3:0] d,
      input logic c1, input logic [31:0] v1, input logic c2, input logic [31:0] v2);
    instruction_element_t e;
    e.opcode = op; e.ROB_dest = d;
    e.CB1 = c1; e.val1 = v1; e.CB2 = c2; e.val2 = v2;
    return e;
  endfunction

  // A broadcast resolves any operand still waiting on that tag.
  function automatic instruction_element_t wake(input instruction_element_t e,
      input logic cv, input logic [3:0] ct, input logic [31:0] cd);
    instruction_element_t r = e;
    if (cv && r.CB1 && r.val1[3:0] == ct) begin r.CB1 = 1'b0; r.val1 = cd; end
    if (cv && r.CB2 && r.val2[3:0] == ct) begin r.CB2 = 1'b0; r.val2 = cd; end
    return r;
  endfunction

  // One clock: drive inputs, check outputs at negedge, advance the model at the edge.
  task automatic step(input string nm, input logic v, input instruction_element_t ins,
      input logic cv, input logic [3:0] ct, input logic [31:0] cd,
      input logic fl, input logic ro);
    int sel;
    logic ev, full;
    instruction_element_t ex;
    vld_i = v; instruction_i = ins; cdb_vld_i = cv; cdb_tag_i = ct;
    cdb_data_i = cd; flush = fl; rdy_o = ro;
    sel = -1;
    foreach (mq[k]) if (sel < 0 && !mq[k].CB1 && !mq[k].CB2) sel = k;
    ev = (sel >= 0) && !fl;
    @(negedge clk);
    chk({nm, ":rdy_i"}, 128'(rdy_i), 128'(mq.size() < DEPTH));
    chk({nm, ":vld_o"}, 128'(vld_o), 128'(ev));
    if (ev) begin
      ex = mq[sel];
      chk({nm, ":instr"}, 128'(instruction_o), 128'(ex));
    end
    full = (mq.size() >= DEPTH);
    if (fl) mq.delete();
    else begin
      if (ev && ro) mq.delete(sel);
      foreach (mq[k]) mq[k] = wake(mq[k], cv, ct, cd);
      if (v && !full) mq.push_back(wake(ins, cv, ct, cd));
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input string nm, input logic ro);
    step(nm, 1'b0, '0, 1'b0, 4'd0, 32'd0, 1'b0, ro);
  endtask

  function automatic instruction_element_t rnd_instr();
    logic c1, c2;
    logic [31:0] v1, v2;
    c1 = 1'($urandom_range(0, 1));
    c2 = 1'($urandom_range(0, 1));
    v1 = $urandom;
    v2 = $urandom;
    if (c1) v1[3:0] = 4'($urandom_range(0, 3));
    if (c2) v2[3:0] = 4'($urandom_range(0, 3));
    return mk(opcode_t'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), c1, v1, c2, v2);
  endfunction

  initial begin
    rst = 1'b1; flush = 1'b0; vld_i = 1'b0; instruction_i = '0;
    cdb_vld_i = 1'b0; cdb_tag_i = '0; cdb_data_i = '0; rdy_o = 1'b0;
    #2;
    chk("reset:rdy_i", 128'(rdy_i), 128'(0));
    chk("reset:vld_o", 128'(vld_o), 128'(0));
    chk("reset:instr", 128'(instruction_o), 128'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    // Ready-at-allocate entry issues the following cycle.
    step("t1_alloc", 1'b1, mk(OP_IMM_ADD, 4'd1, 1'b0, 32'd2, 1'b0, 32'd1), 1'b0, 4'd0, 32'd0, 1'b0, 1'b1);
    idle("t1_issue", 1'b1);
    idle("t1_after", 1'b1);

    // Pending tag 3 resolved by a later broadcast.
    step("t2_alloc", 1'b1, mk(OP_ADD, 4'd2, 1'b1, 32'd3, 1'b0, 32'h10), 1'b0, 4'd0, 32'd0, 1'b0, 1'b1);
    idle("t2_wait", 1'b1);
    step("t2_cdb", 1'b0, '0, 1'b1, 4'd3, 32'hDEADBEEF, 1'b0, 1'b1);
    idle("t2_issue", 1'b1);
    idle("t2_after", 1'b1);

    // Younger ready entry overtakes an older waiting one.
    step("t3_a", 1'b1, mk(OP_SUB, 4'd3, 1'b1, 32'h1234_5675, 1'b0, 32'd7), 1'b0, 4'd0, 32'd0, 1'b0, 1'b1);
    step("t3_b", 1'b1, mk(OP_AND, 4'd4, 1'b0, 32'd9, 1'b0, 32'd6), 1'b0, 4'd0, 32'd0, 1'b0, 1'b1);
    idle("t3_issue_b", 1'b1);
    step("t3_cdb", 1'b0, '0, 1'b1, 4'd5, 32'h55, 1'b0, 1'b1);
    idle("t3_issue_a", 1'b1);
    idle("t3_empty", 1'b1);

    // Fill with tag-7 waiters, reject when full, one broadcast wakes all.
    for (int i = 0; i < DEPTH; i++)
      step("t4_fill", 1'b1, mk(OP_OR, 4'(i), 1'b1, 32'h7, 1'b0, 32'(i)), 1'b0, 4'd0, 32'd0, 1'b0, 1'b1);
    step("t4_full", 1'b1, mk(OP_XOR, 4'd9, 1'b0, 32'd1, 1'b0, 32'd1), 1'b0, 4'd0, 32'd0, 1'b0, 1'b1);
    step("t4_cdb", 1'b1, mk(OP_XOR, 4'd10, 1'b0, 32'd1, 1'b0, 32'd1), 1'b1, 4'd7, 32'hCAFE_0007, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) idle("t4_drain", 1'b1);
    idle("t4_empty", 1'b1);

    // Flush beats allocate and wakeup in the same cycle.
    for (int i = 0; i < 3; i++)
      step("t5_fill", 1'b1, mk(OP_SLL, 4'(i), 1'b1, 32'h9, 1'b1, 32'h9), 1'b0, 4'd0, 32'd0, 1'b0, 1'b1);
    step("t5_flush", 1'b1, mk(OP_SRL, 4'd8, 1'b0, 32'd1, 1'b0, 32'd2), 1'b1, 4'd9, 32'h99, 1'b1, 1'b1);
    idle("t5_post", 1'b1);

    // Stalled output switches to an older entry once it wakes.
    step("t6_a", 1'b1, mk(OP_ADD, 4'd1, 1'b0, 32'd4, 1'b1, 32'h1), 1'b0, 4'd0, 32'd0, 1'b0, 1'b0);
    step("t6_b", 1'b1, mk(OP_SUB, 4'd2, 1'b0, 32'd5, 1'b0, 32'd6), 1'b0, 4'd0, 32'd0, 1'b0, 1'b0);
    idle("t6_stall_b", 1'b0);
    step("t6_cdb", 1'b0, '0, 1'b1, 4'd1, 32'h0A0A_0A0A, 1'b0, 1'b0);
    idle("t6_stall_a", 1'b0);
    idle("t6_issue_a", 1'b1);
    idle("t6_issue_b", 1'b1);

    // Asynchronous reset mid-operation drops everything at once.
    step("t7_a", 1'b1, mk(OP_AND, 4'd3, 1'b0, 32'd1, 1'b0, 32'd2), 1'b0, 4'd0, 32'd0, 1'b0, 1'b0);
    step("t7_b", 1'b1, mk(OP_OR, 4'd4, 1'b0, 32'd3, 1'b0, 32'd4), 1'b0, 4'd0, 32'd0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk("t7_rst:rdy_i", 128'(rdy_i), 128'(0));
    chk("t7_rst:vld_o", 128'(vld_o), 128'(0));
    chk("t7_rst:instr", 128'(instruction_o), 128'(0));
    mq.delete();
    #2;
    rst = 1'b0;
    idle("t7_post", 1'b1);

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      step("rnd",
           1'($urandom_range(0, 9) < 6), rnd_instr(),
           1'($urandom_range(0, 9) < 4), 4'($urandom_range(0, 3)), $urandom,
           1'($urandom_range(0, 99) < 3), 1'($urandom_range(0, 9) < 7));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
